fifo_wt_arbiter: RTL and testbench
==================================

# fifo_wt_arbiter

Round-robin write-port arbiter that shares the single write port of the FIFO datapath (`fifo_dp_top`) among `num_req` requesters in the write clock domain. It grants one requester at a time for a bounded burst, muxes that requester's data onto `data_in_dp` and drives `wt_en_dp`. It never issues a write while `full_st_dp` is high, so `push_on_full_error_dp` cannot be raised through this block.

## Interface
- `data_width`, 4, word width; must match the FIFO data width.
- `num_req`, 4, number of requesters, 2..8.
- `burst_len`, 4, maximum writes per grant, 1..16.

- `wt_clk_arb` in 1: write-domain clock, rising edge.
- `rst_n_in_wt_arb` in 1: reset, asynchronous, active-low.
- `req_arb` in `num_req`: bit n high = requester n presents a valid word.
- `data_in_arb` in `num_req*data_width`: requester n word at `[n*data_width +: data_width]`.
- `full_st_dp` in 1: FIFO full.
- `almost_full_dp` in 1: FIFO almost full.
- `gnt_arb` out `num_req`: one-hot registered grant.
- `ack_arb` out `num_req`: bit n high = requester n's word is written at this edge.
- `wt_en_dp` out 1: FIFO write enable.
- `data_in_dp` out `data_width`: FIFO write data.
- `busy_arb` out 1: high while in BURST.

## Operation
- State registers: `state` (IDLE, BURST), `gnt_arb`, round-robin pointer `ptr` (`$clog2(num_req)` bits), `beat_cnt` (4 bits).
- IDLE:
  - If any `req_arb` bit is high, grant the first set bit searching `ptr`, `ptr+1`, … with wrap at `num_req-1`→0.
  - Load `gnt_arb` with that requester, clear `beat_cnt`, and go to BURST.
  - No write occurs in IDLE.
- BURST, granted requester g:
  - write = `req_arb[g] & !full_st_dp`, combinational.
  - `wt_en_dp` = write; `ack_arb[g]` = write, other bits 0.
  - `data_in_dp` = slice g of `data_in_arb` (0 in IDLE).
  - On a write edge, `beat_cnt` increments.
  - Burst ends when the write at `beat_cnt == burst_len-1` occurs, or at any edge with `req_arb[g]=0` (no write that cycle).
  - On burst end: go to IDLE, clear `gnt_arb`, set `ptr = (g+1) mod num_req`.
- `full_st_dp` high in BURST: stall with no write and no ack; `gnt_arb` and `beat_cnt` are held. The burst does not end on full.
- Requester handshake: hold `req_arb[n]` and the word stable until `ack_arb[n]` is sampled high. The next word may be presented in the cycle after the ack edge.
- `req_arb` deassertion for a non-granted requester has no effect.

## Timing
- Reset values (asynchronous, immediate):
  - `state` = IDLE, `gnt_arb` = 0, `ptr` = 0, `beat_cnt` = 0.
  - Consequently `wt_en_dp` = 0, `ack_arb` = 0, `data_in_dp` = 0, `busy_arb` = 0.
- Grant latency: `req_arb` high before edge k in IDLE → `gnt_arb` high after edge k → first write at edge k+1 (if not full).
- A full `burst_len`=4 burst writes at edges k+1..k+4 and returns to IDLE after k+4. The next grant is at k+5, with its first write at k+6.
- There is one idle arbitration cycle between every pair of bursts.
- `wt_en_dp`, `ack_arb` and `data_in_dp` are combinational from state and inputs. `full_st_dp` is sampled in the same cycle it gates the write.
- Simultaneous events:
  - A final beat at a cycle where `req_arb[g]` is also still high still ends the burst.
  - Full asserted on the intended last beat: the beat is stalled and the burst continues until it completes.
- Reset mid-burst: outputs drop immediately. An un-acked word is not written, and the requester must re-present it. After release, arbitration restarts from `ptr`=0.

## Configuration
- `ARB_ALMOST_FULL_THROTTLE_EN` defined: IDLE does not grant while `almost_full_dp`=1; the state stays IDLE. Bursts already in progress are unaffected.
- Undefined: `almost_full_dp` is ignored; only `full_st_dp` gates writes.

## Test plan
- Reset: assert `rst_n_in_wt_arb`=0 mid-simulation with `req_arb`=4'b1111 → `gnt_arb`=0, `wt_en_dp`=0, `ack_arb`=0, `busy_arb`=0 within the same timestep.
- Single requester 1 supplies words 1..6, `burst_len`=4 → writes 1,2,3,4 on consecutive edges, one idle cycle, regrant to 1, writes 5,6, then IDLE when req drops. `ack_arb`=4'b0010 on each write.
- `req_arb`=4'b1111 held, each requester sending its index → grant order 0,1,2,3,0; four writes each; FIFO contents 0000,1111,2222,3333.
- `full_st_dp`=1 for 3 cycles after beat 2 of requester 2's burst → `wt_en_dp`=0 and `ack_arb`=0 for 3 cycles, `gnt_arb`=4'b0100 held, then beats 3–4 complete and `ptr`=3.
- `almost_full_dp`=1 in IDLE with `req_arb`=4'b0001 → with `ARB_ALMOST_FULL_THROTTLE_EN`: no grant until `almost_full_dp`=0. Without it: grant at the next edge.
- Reset pulse after 2 beats of requester 3's burst → outputs 0 immediately. After release with `req_arb`=4'b1001, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_wt_arbiter.sv
// ============================================================================
// Module  : fifo_wt_arbiter
// Purpose : Round-robin, burst-limited arbiter sharing the FIFO write port
//           among NUM_REQ requesters; never writes while the FIFO is full.
//           Optional macro ARB_ALMOST_FULL_THROTTLE_EN blocks new grants
//           while almost_full_dp is high.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wt_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          wt_clk_arb,
  input  logic                          rst_n_in_wt_arb,
  input  logic [NUM_REQ-1:0]            req_arb,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in_arb,
  input  logic                          full_st_dp,
  input  logic                          almost_full_dp,
  output logic [NUM_REQ-1:0]            gnt_arb,
  output logic [NUM_REQ-1:0]            ack_arb,
  output logic                          wt_en_dp,
  output logic [DATA_WIDTH-1:0]         data_in_dp,
  output logic                          busy_arb
);

  localparam int         PW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] C_LAST_BEAT = 4'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt,   w_gnt_nxt;
  logic [PW-1:0]        r_ptr,   w_ptr_nxt;
  logic [3:0]           r_beat,  w_beat_nxt;

  logic [PW-1:0]        w_sel;
  logic [PW:0]          w_sum;
  logic [PW-1:0]        w_gidx;
  logic                 w_greq;
  logic                 w_write;
  logic                 w_throttle;
  logic [DATA_WIDTH-1:0] w_data;

`ifdef ARB_ALMOST_FULL_THROTTLE_EN
  assign w_throttle = almost_full_dp;
`else
  assign w_throttle = 1'b0 & almost_full_dp;
`endif

  // Round-robin pick: the loop runs from the farthest offset down so the
  // first set bit at or after r_ptr is the last one assigned.
  always_comb begin
    w_sel = '0;
    w_sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PW+1)'(NUM_REQ);
      end
      if (req_arb[w_sum[PW-1:0]]) begin
        w_sel = w_sum[PW-1:0];
      end
    end
  end

  // Decode the one-hot grant into an index and route the granted word.
  always_comb begin
    w_gidx = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) begin
        w_gidx = PW'(i);
        w_data = w_data | data_in_arb[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_greq     = |(req_arb & r_gnt);
  assign w_write    = (r_state == S_BURST) & w_greq & ~full_st_dp;
  assign wt_en_dp   = w_write;
  assign ack_arb    = r_gnt & {NUM_REQ{w_write}};
  assign data_in_dp = (r_state == S_BURST) ? w_data : '0;
  assign gnt_arb    = r_gnt;
  assign busy_arb   = (r_state == S_BURST);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    case (r_state)
      S_IDLE: begin
        if ((|req_arb) && !w_throttle) begin
          w_gnt_nxt   = NUM_REQ'(1) << w_sel;
          w_beat_nxt  = '0;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        // Full alone only stalls; a burst ends on its last write or on
        // the granted requester withdrawing.
        if ((w_write && (r_beat == C_LAST_BEAT)) || !w_greq) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_beat_nxt  = '0;
          w_ptr_nxt   = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
        end else if (w_write) begin
          w_beat_nxt = r_beat + 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wt_clk_arb or negedge rst_n_in_wt_arb) begin
    if (!rst_n_in_wt_arb) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wt_arbiter.sv
// ============================================================================
// Module  : tb_fifo_wt_arbiter
// Purpose : Randomized scoreboard bench for fifo_wt_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wt_arbiter;
  localparam int DW = 4;
  localparam int NR = 4;
  localparam int BL = 4;
`ifdef ARB_ALMOST_FULL_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req   = '0;
  logic [NR*DW-1:0]  din   = '0;
  logic              full  = 1'b0;
  logic              af    = 1'b0;
  logic [NR-1:0]     gnt, ack;
  logic              wt_en, busy;
  logic [DW-1:0]     dout;

  fifo_wt_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
    .wt_clk_arb      (clk),
    .rst_n_in_wt_arb (rst_n),
    .req_arb         (req),
    .data_in_arb     (din),
    .full_st_dp      (full),
    .almost_full_dp  (af),
    .gnt_arb         (gnt),
    .ack_arb         (ack),
    .wt_en_dp        (wt_en),
    .data_in_dp      (dout),
    .busy_arb        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[NR][$];
  logic [DW-1:0] word[NR];
  bit            pending[NR];
  int            p_new = 0, p_full = 0, p_af = 0;
  logic [NR-1:0] en_mask = '0;

  // Reference model: who owns the port, where the round robin resumes,
  // and how many words the current owner has written.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: evaluated mid-cycle when inputs are stable.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_owner = -1; m_ptr = 0; m_beats = 0;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wt_en", 32'(wt_en), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
      end else begin
        bit exp_w;
        exp_w = (m_owner >= 0) && req[m_owner] && !full;
        chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("wt_en", 32'(wt_en), 32'(exp_w));
        chk("ack", 32'(ack), exp_w ? (32'd1 << m_owner) : 32'd0);
        if (m_owner < 0) chk("idle_data", 32'(dout), 0);
        if (exp_w) begin
          if (exp_q[m_owner].size() == 0) begin
            chk("sb_underflow", 32'(exp_q[m_owner].size()), 1);
          end else begin
            logic [DW-1:0] ed;
            ed = exp_q[m_owner].pop_front();
            chk("data", 32'(dout), 32'(ed));
          end
        end
        // Advance the model across the coming rising edge.
        if (m_owner < 0) begin
          if ((|req) && !(THR && af)) begin
            for (int i = 0; i < NR; i++) begin
              int c;
              c = (m_ptr + i) % NR;
              if (req[c]) begin
                m_owner = c;
                m_beats = 0;
                break;
              end
            end
          end
        end else if (exp_w) begin
          m_beats++;
          if (m_beats == BL) begin
            m_ptr = (m_owner + 1) % NR;
            m_owner = -1;
          end
        end else if (!req[m_owner]) begin
          m_ptr = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end
    end
  end

  // One clock of stimulus: retire acked words, maybe offer new ones.
  task automatic cycle();
    logic [NR-1:0] ackv;
    @(negedge clk);
    ackv = ack;
    @(posedge clk);
    #1;
    for (int n = 0; n < NR; n++) begin
      if (ackv[n]) pending[n] = 1'b0;
      if (!pending[n] && en_mask[n] && ($urandom_range(99) < p_new)) begin
        word[n]    = DW'($urandom);
        pending[n] = 1'b1;
        exp_q[n].push_back(word[n]);
      end
      req[n]          = pending[n];
      din[n*DW +: DW] = word[n];
    end
    full = ($urandom_range(99) < p_full);
    af   = ($urandom_range(99) < p_af);
  endtask

  function automatic bit all_idle();
    bit r;
    r = (m_owner < 0);
    for (int n = 0; n < NR; n++) if (pending[n]) r = 1'b0;
    return r;
  endfunction

  task automatic drain();
    en_mask = '0;
    for (int i = 0; i < 500 && !all_idle(); i++) cycle();
    chk("drain_done", 32'(all_idle()), 1);
  endtask

  initial begin
    bit got;
    for (int n = 0; n < NR; n++) begin
      word[n] = '0; pending[n] = 1'b0;
    end
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("init_rst_gnt", 32'(gnt), 0);
    chk("init_rst_wt_en", 32'(wt_en), 0);
    chk("init_rst_ack", 32'(ack), 0);
    chk("init_rst_busy", 32'(busy), 0);
    repeat (3) cycle();
    rst_n = 1'b1;

    // Mixed random traffic with stalls and almost-full noise
    en_mask = 4'b1111; p_new = 60; p_full = 20; p_af = 20;
    repeat (600) cycle();
    drain();

    // Single requester streaming without stalls
    en_mask = 4'b0010; p_new = 100; p_full = 0; p_af = 0;
    repeat (60) cycle();
    drain();

    // All requesters saturated, heavy full back-pressure
    en_mask = 4'b1111; p_new = 100; p_full = 30;
    repeat (400) cycle();
    drain();

    // Almost-full while idle with only requester 0 asking
    p_full = 0; p_af = 100; p_new = 100; en_mask = 4'b0001;
    got = 1'b0;
    repeat (6) begin
      cycle();
      if (gnt[0]) got = 1'b1;
    end
    chk("af_grant_seen", 32'(got), THR ? 32'd0 : 32'd1);
    p_af = 0;
    drain();

    // Reset in the middle of requester 3's burst
    en_mask = 4'b1000; p_new = 100; p_full = 0;
    for (int i = 0; i < 200 && !(m_owner == 3 && m_beats == 2); i++) cycle();
    chk("reached_beat2", 32'(m_owner == 3 && m_beats == 2), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_wt_en", 32'(wt_en), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(dout), 0);
    en_mask = 4'b1001;
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) cycle();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    drain();

    // Final random soak
    en_mask = 4'b1111; p_new = 50; p_full = 25; p_af = 25;
    repeat (400) cycle();
    drain();
    for (int n = 0; n < NR; n++) chk("sb_empty", 32'(exp_q[n].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
